// File: rtl/itch_pkg.sv
// Shared types and defaults for the ITCH frame sequencer: FSM states,
// header geometry and the protocol values checked in the header.
package itch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    localparam int unsigned HDR_BEATS  = 8;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_UDP  = 8'd17;

    // Header beats carrying the EtherType and the IP protocol byte
    localparam logic [6:0] IDX_ETYPE = 7'd1;
    localparam logic [6:0] IDX_PROTO = 7'd3;

endpackage

// File: rtl/itch_frame_stats.sv
// Frame counters (wrapping) and registered one-cycle error pulses,
// driven by single-cycle event strobes from the sequencer FSM.
module itch_frame_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_ok,
    input  logic        inc_drop,
    input  logic        runt,
    input  logic        proto,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop,
    output logic        err_runt,
    output logic        err_proto
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_ok   <= '0;
            frames_drop <= '0;
            err_runt    <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            err_runt  <= runt;
            err_proto <= proto;
            if (inc_ok)
                frames_ok <= frames_ok + 16'd1;
            if (inc_drop)
                frames_drop <= frames_drop + 16'd1;
        end
    end

endmodule

// File: rtl/itch_frame_sequencer.sv
// Splits an incoming 64-bit beat stream into header beats (indexed for the
// field decoders) and a zero-latency payload stream, dropping bad frames.
module itch_frame_sequencer #(
    parameter int unsigned HDR_BEATS  = itch_pkg::HDR_BEATS,
    parameter logic [15:0] ETYPE_IPV4 = itch_pkg::ETYPE_IPV4,
    parameter logic [7:0]  PROTO_UDP  = itch_pkg::PROTO_UDP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [63:0] rx_data,
    output logic        rx_ready,
    output logic [6:0]  beat_idx,
    output logic        beat_en,
    output logic        hdr_valid,
    output logic        pay_valid,
    output logic [63:0] pay_data,
    output logic        pay_last,
    input  logic        pay_ready,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop,
    output logic        err_runt,
    output logic        err_proto
);

    import itch_pkg::*;

    localparam logic [6:0] LAST_IDX = 7'(HDR_BEATS - 1);

    state_t     state;
    state_t     state_next;
    logic [6:0] hdr_cnt;
    logic [6:0] hdr_cnt_next;
    logic [6:0] idx_last;
    logic [6:0] cur_idx;
    logic       accept;
    logic       sop_acc;
    logic       eop_acc;
    logic       abort;
    logic       bad_hdr;
    logic       hdr_done;
    logic       inc_ok;
    logic       inc_drop;
    logic       runt;
    logic       proto;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt   <= '0;
            idx_last  <= '0;
            hdr_valid <= 1'b0;
        end else begin
            hdr_cnt   <= hdr_cnt_next;
            hdr_valid <= hdr_done;
            if (beat_en)
                idx_last <= cur_idx;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state;
        hdr_cnt_next = hdr_cnt;
        if (beat_en) begin
            hdr_cnt_next = cur_idx + 7'd1;
            if (eop_acc)
                state_next = IDLE;
            else if (bad_hdr)
                state_next = DROP;
            else if (hdr_done)
                state_next = PAYLOAD;
            else
                state_next = HDR;
        end else if (eop_acc) begin
            state_next = IDLE;
        end
    end

    // Outputs and event strobes
    always_comb begin
        rx_ready = (state == PAYLOAD) ? pay_ready : 1'b1;
        accept   = rx_valid & rx_ready;
        sop_acc  = accept & rx_sop;
        eop_acc  = accept & rx_eop;
        abort    = sop_acc & (state != IDLE);
        // Any accepted sop restarts the header, whatever the current state
        beat_en  = sop_acc | (accept & (state == HDR));
        cur_idx  = sop_acc ? '0 : hdr_cnt;
        beat_idx = beat_en ? cur_idx : idx_last;
        bad_hdr  = beat_en &
                   (((cur_idx == IDX_ETYPE) && (rx_data[63:48] != ETYPE_IPV4)) ||
                    ((cur_idx == IDX_PROTO) && (rx_data[15:8]  != PROTO_UDP)));
        hdr_done = beat_en & ~bad_hdr & (cur_idx == LAST_IDX);

        pay_valid = (state == PAYLOAD) & rx_valid & ~rx_sop;
        pay_data  = rx_data;
        pay_last  = pay_valid & rx_eop;

        inc_ok   = 1'b0;
        inc_drop = 1'b0;
        runt     = 1'b0;
        proto    = 1'b0;
        if (abort) begin
            inc_drop = 1'b1;
            runt     = 1'b1;
        end else if (beat_en) begin
            if (bad_hdr) begin
                proto    = 1'b1;
                inc_drop = eop_acc;
            end else if (hdr_done) begin
                inc_ok = eop_acc;
            end else if (eop_acc) begin
                runt     = 1'b1;
                inc_drop = 1'b1;
            end
        end else if (eop_acc) begin
            inc_ok   = (state == PAYLOAD);
            inc_drop = (state == DROP);
        end
    end

    itch_frame_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .inc_ok      (inc_ok),
        .inc_drop    (inc_drop),
        .runt        (runt),
        .proto       (proto),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop),
        .err_runt    (err_runt),
        .err_proto   (err_proto)
    );

endmodule

// File: doc/itch_frame_sequencer.md
ITCH_FRAME_SEQUENCER -- requirements
Module: itch_frame_sequencer

Interface
REQ-001 Parameter HDR_BEATS, default 8, number of 64-bit header beats (Ethernet, IP, UDP and MoldUDP64) before payload.
REQ-002 Parameter ETYPE_IPV4, default 16'h0800, accepted EtherType value.
REQ-003 Parameter PROTO_UDP, default 8'd17, accepted IP protocol value.
REQ-004 clk  in  1  clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rx_valid  in  1  input beat valid.
REQ-007 rx_sop  in  1  first beat of frame, qualified by rx_valid.
REQ-008 rx_eop  in  1  last beat of frame, qualified by rx_valid.
REQ-009 rx_data  in  64  input beat.
REQ-010 rx_ready  out  1  beat accepted when rx_valid and rx_ready are both 1.
REQ-011 beat_idx  out  7  header beat index that drives the decoder case selects.
REQ-012 beat_en  out  1  beat_idx and rx_data are valid for the decoders this cycle.
REQ-013 hdr_valid  out  1  one-cycle pulse: decoded header fields are stable.
REQ-014 pay_valid, pay_data[63:0], pay_last  out  payload stream.
REQ-015 pay_ready  in  1  downstream payload ready.
REQ-016 frames_ok, frames_drop  out  16 each  wrapping frame counters.
REQ-017 err_runt, err_proto  out  1 each  one-cycle error pulses.

Function
REQ-018 FSM states: IDLE, HDR, PAYLOAD, DROP; reset state is IDLE.
REQ-019 IDLE: rx_ready=1; an accepted beat with sop=1 goes to HDR with beat_en=1, beat_idx=0; beats accepted with sop=0 are discarded with no count.
REQ-020 HDR: each accepted beat asserts beat_en with the current beat_idx in the same cycle; beat_idx then increments.
REQ-021 Accepted beat 1: rx_data[63:48] != ETYPE_IPV4 -> err_proto pulse, go to DROP (or to IDLE if eop).
REQ-022 Accepted beat 3: rx_data[15:8] != PROTO_UDP -> same as REQ-021.
REQ-023 Accepted beat HDR_BEATS-1 with no error -> hdr_valid pulses the next cycle, then go to PAYLOAD (to IDLE if eop, with the frame counted OK).
REQ-024 eop accepted in HDR before beat HDR_BEATS-1 -> err_runt pulse, frames_drop+1, go to IDLE; no hdr_valid.
REQ-025 PAYLOAD: rx_ready=pay_ready; pay_valid=rx_valid; pay_data=rx_data; pay_last=rx_eop (combinational pass-through, zero latency).
REQ-026 Accepted eop in PAYLOAD -> frames_ok+1, go to IDLE.
REQ-027 DROP: rx_ready=1; beats are discarded; accepted eop -> frames_drop+1, go to IDLE.
REQ-028 Accepted sop in HDR, PAYLOAD or DROP (frame abort): frames_drop+1, err_runt pulse, restart HDR at beat_idx=0 with that beat as beat 0.
REQ-029 If a single beat has sop=1 and eop=1 in IDLE, it is a runt: beat_en=1, err_runt pulses, frames_drop+1, and the FSM stays in IDLE.
REQ-030 beat_en=0 outside HDR; beat_idx holds its last value when beat_en=0.
REQ-031 rx_ready=1 in HDR; the header is never backpressured.
REQ-032 pay_valid=0 outside PAYLOAD.
REQ-033 Counters wrap from 16'hFFFF to 0 without a flag.
REQ-034 Each accepted beat increments at most one counter.

Reset
REQ-035 Reset values: state IDLE, beat_idx=0, beat_en=0, hdr_valid=0, error pulses 0, frames_ok=0, frames_drop=0, pay_valid=0.
REQ-036 Reset mid-frame discards the frame without any count; after reset release, the block waits for the next sop.

Structure
REQ-037 itch_pkg holds the state enum, HDR_BEATS, ETYPE_IPV4, PROTO_UDP, and the beat-index constants for the EtherType (1) and protocol (3) checks.
REQ-038 The counters and error pulses are in a sub-module, itch_frame_stats; the FSM and datapath muxing stay in the top level.

Verification
REQ-039 Valid 10-beat frame (etype 0x0800, proto 17), pay_ready=1 -> beat_en with beat_idx 0..7, hdr_valid one cycle later, 2 payload beats with pay_last on the second, frames_ok=1.
REQ-040 Beat 1 with etype 0x86DD -> err_proto pulse, no hdr_valid, no pay_valid, frames_drop=1 at eop.
REQ-041 eop at beat 4 -> err_runt pulse, frames_drop=1, next sop is accepted as beat 0.
REQ-042 pay_ready low for 3 cycles in PAYLOAD -> rx_ready low for those 3 cycles, no beat lost or duplicated, data order preserved.
REQ-043 sop at beat 5 of frame A -> frames_drop+1, frame B decodes beat_idx 0..7 and completes OK.
REQ-044 Preload frames_ok to 16'hFFFF, send one good frame -> frames_ok=0; assert rst at beat 3 -> all outputs at reset values, no count change.
